// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pkg
//  Purpose  : Shared state encodings, AXI3 constants and kseg address mapping
//             for the AXI read arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    READ_IDLE = 2'd0,
    READ_ADDR = 2'd1,
    READ_DATA = 2'd2
  } read_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] PROT_DATA  = 3'b001;

  // kseg0 (100) and kseg1 (101) alias the low physical window; clear [31:29].
  function automatic logic [31:0] kseg_map(input logic [31:0] addr);
    logic [31:0] v_addr;
    v_addr = addr;
    if (addr[31:30] == 2'b10) begin
      v_addr[31:29] = 3'b000;
    end
    return v_addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_read_arbiter_if
//  Purpose  : AXI3 read address / read data channel bundle. The arbiter uses
//             the master view, the interconnect (or a bench) the slave view.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_r_skid.sv
`default_nettype none
// ============================================================================
//  Module   : axi_r_skid
//  Purpose  : One-entry R-channel response buffer (data/last/err) with a
//             valid/ready handshake on both sides and a synchronous clear.
//             Simultaneous consume and capture keeps the entry full, so the
//             buffer sustains one beat per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_r_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_clear,
  input  wire logic                  i_valid,
  output logic                       o_ready,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  input  wire logic                  i_last,
  input  wire logic                  i_err,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_last,
  output logic                       o_err,
  input  wire logic                  i_ready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_err;

  // Space exists when empty or when the held beat leaves this cycle.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_err   = r_err;

  // Capture an incoming beat, drain a consumed one; clear wins over both.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_err   <= i_err;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_read_arbiter
//  Purpose  : Fixed-priority arbiter placing NUM_PORTS read requestors onto a
//             single AXI3 AR/R channel (port 0 highest). One transaction in
//             flight; a flush drops the current burst while still completing
//             the AXI handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 4,
  parameter int MAP_KSEG   = 1
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  input  wire logic [NUM_PORTS-1:0]            req_valid,
  input  wire logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  wire logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_PORTS-1:0]                 req_ready,
  output logic [NUM_PORTS-1:0]                 resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_data,
  output logic                                 resp_last,
  output logic                                 resp_err,
  input  wire logic [NUM_PORTS-1:0]            resp_ready,
  input  wire logic                            flush,
  output logic                                 busy,
  axi_read_arbiter_if.master                   axi
);

  localparam logic [2:0] c_arsize = 3'($clog2(DATA_WIDTH / 8));

  read_state_t           r_state;
  logic                  r_drop;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [LEN_WIDTH-1:0]  r_arlen;
  logic                  r_arvalid;

  logic [NUM_PORTS-1:0]  w_grant;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [ADDR_WIDTH-1:0] w_map_addr;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic                  w_sel_ready;
  logic                  w_accept;
  logic                  w_rready;
  logic                  w_beat;
  logic                  w_clear;
  logic                  w_buf_in_valid;
  logic                  w_buf_in_ready;
  logic                  w_buf_valid;
  logic                  w_buf_last;
  logic                  w_buf_ready;
  logic                  w_consume;

  // Lowest-index requester wins; its address and length are picked alongside.
  always_comb begin : p_grant
    logic v_blocked;
    v_blocked  = 1'b0;
    w_grant    = '0;
    w_gnt_id   = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid[i] && !v_blocked) begin
        w_grant[i] = 1'b1;
        w_gnt_id   = ID_WIDTH'(i);
        w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
      v_blocked = v_blocked | req_valid[i];
    end
  end

  generate
    if (MAP_KSEG != 0 && ADDR_WIDTH == 32) begin : g_kseg
      assign w_map_addr = kseg_map(w_sel_addr);
    end else begin : g_no_kseg
      assign w_map_addr = w_sel_addr;
    end
  endgenerate

  // Requests are only taken while idle; the grant is a single-cycle pulse.
  assign req_ready = (r_state == READ_IDLE && !reset) ? w_grant : '0;

  // Route the granted port's resp_ready back and fan resp_valid out to it.
  always_comb begin
    w_sel_ready = 1'b0;
    resp_valid  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_arid == ID_WIDTH'(i)) begin
        w_sel_ready   = resp_ready[i];
        resp_valid[i] = w_accept && w_buf_valid;
      end
    end
  end

  // Beats are delivered only in DATA without a pending drop.
  assign w_accept       = (r_state == READ_DATA) && !r_drop;
  assign w_clear        = (r_state == READ_DATA) && (r_drop || flush);
  assign w_buf_in_valid = axi.rvalid && w_accept;
  assign w_buf_ready    = w_accept && w_sel_ready;
  assign w_consume      = w_buf_valid && w_buf_ready;
  assign w_rready       = (r_state == READ_DATA) && (r_drop || w_buf_in_ready);
  assign w_beat         = axi.rvalid && w_rready;

  axi_r_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_clear),
    .i_valid (w_buf_in_valid),
    .o_ready (w_buf_in_ready),
    .i_data  (axi.rdata),
    .i_last  (axi.rlast),
    .i_err   (axi.rresp != RESP_OKAY),
    .o_valid (w_buf_valid),
    .o_data  (resp_data),
    .o_last  (w_buf_last),
    .o_err   (resp_err),
    .i_ready (w_buf_ready)
  );

  assign resp_last = w_buf_last;
  assign busy      = (r_state != READ_IDLE);

  assign axi.arid    = r_arid;
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = r_arlen;
  assign axi.arsize  = c_arsize;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = PROT_DATA;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = w_rready;

  // Transaction sequencer: grant, address handshake, data (or drop) phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= READ_IDLE;
      r_drop    <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arvalid <= 1'b0;
    end else begin
      case (r_state)
        READ_IDLE: begin
          if (|req_valid) begin
            r_arid    <= w_gnt_id;
            r_araddr  <= w_map_addr;
            r_arlen   <= w_sel_len;
            r_arvalid <= 1'b1;
            r_state   <= READ_ADDR;
          end
        end
        READ_ADDR: begin
          if (flush) begin
            r_drop <= 1'b1;
          end
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_state   <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (r_drop) begin
            if (axi.rvalid && axi.rlast) begin
              r_drop  <= 1'b0;
              r_state <= READ_IDLE;
            end
          end else if (flush) begin
            // If the final beat already arrived (buffered or landing now)
            // there is nothing left to drain, so return straight to idle.
            if ((w_buf_valid && w_buf_last) || (w_beat && axi.rlast)) begin
              r_state <= READ_IDLE;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (w_consume && w_buf_last) begin
            r_state <= READ_IDLE;
          end
        end
        default: begin
          r_state <= READ_IDLE;
        end
      endcase
    end
  end

  // A returning beat must carry the ID of the outstanding request.
  a_rid_match : assert property (@(posedge clk) disable iff (reset)
    (r_state == READ_DATA && axi.rvalid && w_rready) |-> (axi.rid == r_arid));

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_read_arbiter
//  Purpose  : Directed self-checking bench for axi_read_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic [1:0]  resp_ready;
  logic        flush;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  axi_read_arbiter_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (4),
    .ID_WIDTH   (4)
  ) axi ();

  axi_read_arbiter #(
    .NUM_PORTS  (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (4),
    .ID_WIDTH   (4),
    .MAP_KSEG   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .flush      (flush),
    .busy       (busy),
    .axi        (axi.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request on one port for one cycle and check the grant.
  task automatic do_request(input int port, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] exp_ready);
    req_valid[port]           = 1'b1;
    req_addr[port*32 +: 32]   = addr;
    req_len[port*4 +: 4]      = len;
    #1;
    check_eq("req_ready", req_ready, exp_ready);
    tick();
    req_valid[port] = 1'b0;
  endtask

  // In ADDR: check AR fields, complete the handshake immediately.
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    #1;
    check_eq("arvalid", axi.arvalid, 1'b1);
    check_eq("arid", axi.arid, id);
    check_eq("araddr", axi.araddr, addr);
    check_eq("arlen", axi.arlen, len);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    #1;
    check_eq("arvalid_drop", axi.arvalid, 1'b0);
  endtask

  // Act as the R-channel slave for a burst and as the consuming port.
  // Backpressure: resp_ready held low for 'stall' cycles once the first
  // beat becomes visible.
  task automatic run_burst(input int port, input int nbeats, input logic [31:0] base,
                           input int stall, input logic [1:0] resp0);
    int  k = 0;
    int  c = 0;
    int  budget = 0;
    int  stall_left = 0;
    bit  seen = 1'b0;
    bit  hs_r;
    bit  hs_c;
    logic [1:0] other;
    while (c < nbeats && budget < 200) begin
      budget++;
      axi.rvalid = (k < nbeats);
      axi.rdata  = base + k;
      axi.rlast  = (k == nbeats - 1);
      axi.rid    = 4'(port);
      axi.rresp  = (k == 0) ? resp0 : 2'b00;
      #1;
      if (resp_valid[port] && !seen) begin
        seen       = 1'b1;
        stall_left = stall;
      end
      resp_ready = '0;
      if (stall_left == 0) resp_ready[port] = 1'b1;
      #1;
      other = resp_valid;
      other[port] = 1'b0;
      check_eq("other_valid", other, 2'b00);
      hs_r = axi.rvalid && axi.rready;
      hs_c = resp_valid[port] && resp_ready[port];
      if (resp_valid[port] && !resp_ready[port]) check_eq("stall_rready", axi.rready, 1'b0);
      if (hs_c) begin
        check_eq("beat_data", resp_data, base + c);
        check_eq("beat_last", resp_last, (c == nbeats - 1));
        check_eq("beat_err", resp_err, (c == 0) && (resp0 != 2'b00));
      end
      if (resp_valid[port] && stall_left > 0) stall_left--;
      tick();
      if (hs_r) k++;
      if (hs_c) c++;
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    resp_ready = '0;
    check_eq("burst_count", c, nbeats);
    #1;
    check_eq("burst_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_len     = '0;
    resp_ready  = '0;
    flush       = 1'b0;
    axi.arready = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_arvalid", axi.arvalid, 1'b0);
    check_eq("rst_rready", axi.rready, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 2'b00);
    reset = 1'b0;
    tick();

    // Single beat, port 1, kseg1 mapping; flush while idle is ignored.
    flush = 1'b1;
    do_request(1, 32'hBFC0_0000, 4'd0, 2'b10);
    flush = 1'b0;
    #1;
    check_eq("arsize", axi.arsize, 3'd2);
    check_eq("arburst", axi.arburst, 2'b01);
    check_eq("arprot", axi.arprot, 3'b001);
    check_eq("arlock_cache", {axi.arlock, axi.arcache}, 6'd0);
    check_eq("busy_addr", busy, 1'b1);
    do_ar(4'd1, 32'h1FC0_0000, 4'd0);
    check_eq("data_rready", axi.rready, 1'b1);
    check_eq("data_no_valid", resp_valid, 2'b00);
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h3C1D_BFC0;
    axi.rlast  = 1'b1;
    axi.rid    = 4'd1;
    axi.rresp  = 2'b00;
    resp_ready = 2'b10;
    tick();
    axi.rvalid = 1'b0;
    #1;
    check_eq("t1_resp_valid", resp_valid, 2'b10);
    check_eq("t1_resp_data", resp_data, 32'h3C1D_BFC0);
    check_eq("t1_resp_last", resp_last, 1'b1);
    check_eq("t1_resp_err", resp_err, 1'b0);
    tick();
    resp_ready = '0;
    #1;
    check_eq("t1_idle", busy, 1'b0);

    // Priority: both request together; port 0 first, port 1 next idle cycle.
    req_valid = 2'b11;
    req_addr  = {32'hBFC0_0004, 32'h8000_1000};
    req_len   = 8'h00;
    #1;
    check_eq("prio_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    check_eq("prio_busy_ready", req_ready, 2'b00);
    do_ar(4'd0, 32'h0000_1000, 4'd0);
    run_burst(0, 1, 32'h1111_1111, 0, 2'b00);
    check_eq("prio_port1_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    do_ar(4'd1, 32'h1FC0_0004, 4'd0);
    run_burst(1, 1, 32'h2222_2222, 0, 2'b00);

    // Four-beat burst with two cycles of consumer backpressure.
    do_request(0, 32'h0000_2000, 4'd3, 2'b01);
    do_ar(4'd0, 32'h0000_2000, 4'd3);
    run_burst(0, 4, 32'h0000_00A0, 2, 2'b00);

    // Flush in ADDR, arready held off three cycles, two beats drained.
    do_request(0, 32'h0000_3000, 4'd1, 2'b01);
    flush = 1'b1;
    #1;
    check_eq("fl_arvalid0", axi.arvalid, 1'b1);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("fl_arvalid_hold", axi.arvalid, 1'b1);
      check_eq("fl_araddr_hold", axi.araddr, 32'h0000_3000);
      tick();
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rid     = 4'd0;
    axi.rdata   = 32'hDEAD_0000;
    axi.rlast   = 1'b0;
    resp_ready  = 2'b01;
    #1;
    check_eq("fl_rready0", axi.rready, 1'b1);
    check_eq("fl_busy0", busy, 1'b1);
    tick();
    axi.rdata = 32'hDEAD_0001;
    axi.rlast = 1'b1;
    #1;
    check_eq("fl_rready1", axi.rready, 1'b1);
    check_eq("fl_resp_valid", resp_valid, 2'b00);
    check_eq("fl_busy1", busy, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    resp_ready = '0;
    #1;
    check_eq("fl_done", busy, 1'b0);
    check_eq("fl_resp_valid_end", resp_valid, 2'b00);

    // Error response, then reset in the middle of the burst.
    do_request(1, 32'h0000_4000, 4'd2, 2'b10);
    do_ar(4'd1, 32'h0000_4000, 4'd2);
    axi.rvalid = 1'b1;
    axi.rid    = 4'd1;
    axi.rdata  = 32'h0000_0055;
    axi.rresp  = 2'b10;
    axi.rlast  = 1'b0;
    tick();
    axi.rdata = 32'h0000_0056;
    axi.rresp = 2'b00;
    #1;
    check_eq("err_valid", resp_valid, 2'b10);
    check_eq("err_flag", resp_err, 1'b1);
    check_eq("err_data", resp_data, 32'h0000_0055);
    reset = 1'b1;
    tick();
    axi.rvalid = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_arvalid", axi.arvalid, 1'b0);
    check_eq("mrst_arid", axi.arid, 4'd0);
    check_eq("mrst_araddr", axi.araddr, 32'd0);
    check_eq("mrst_arlen", axi.arlen, 4'd0);
    check_eq("mrst_rready", axi.rready, 1'b0);
    check_eq("mrst_resp_valid", resp_valid, 2'b00);
    reset = 1'b0;
    tick();
    do_request(0, 32'hA000_0010, 4'd0, 2'b01);
    do_ar(4'd0, 32'h0000_0010, 4'd0);
    run_burst(0, 1, 32'h7777_0000, 0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Parametrised AXI3 read-channel master that arbitrates NUM_PORTS requestors onto one AR/R channel. It generalises the single IF/MEM read adapter.
- Each port gets a valid/ready request handshake, bursts of up to 2^LEN_WIDTH beats, and a registered response with a one-entry R-channel buffer.
- A flush input discards an in-flight transaction without breaking AXI protocol.
- Sits between the pipeline fetch/load units and the AXI interconnect.

Parameters:
- NUM_PORTS, 2, number of requestors; port 0 has highest priority (MEM=0, IF=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; power of two, 8..64.
- LEN_WIDTH, 4, width of arlen (AXI3).
- ID_WIDTH, 4, width of arid/rid; must satisfy 2^ID_WIDTH >= NUM_PORTS.
- MAP_KSEG, 1, when 1, addresses with [31:29]=100 or 101 have [31:29] cleared (kseg0/kseg1 to physical).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port read request.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address (packed, port 0 in LSBs).
- req_len  in  NUM_PORTS*LEN_WIDTH  per-port beats-1.
- req_ready  out  NUM_PORTS  request accepted this cycle.
- resp_valid  out  NUM_PORTS  response beat valid.
- resp_data  out  DATA_WIDTH  shared response data.
- resp_last  out  1  final beat of burst.
- resp_err  out  1  rresp != OKAY for this beat.
- resp_ready  in  NUM_PORTS  port accepts beat.
- flush  in  1  abandon the current transaction.
- busy  out  1  state != IDLE.
- arid  out  ID_WIDTH.
- araddr  out  ADDR_WIDTH.
- arlen  out  LEN_WIDTH.
- arsize  out  3.
- arburst  out  2.
- arlock  out  2.
- arcache  out  4.
- arprot  out  3.
- arvalid  out  1.
- arready  in  1.
- rid  in  ID_WIDTH.
- rdata  in  DATA_WIDTH.
- rresp  in  2.
- rlast  in  1.
- rvalid  in  1.
- rready  out  1.

Behaviour:
- Constant AR fields: arsize=log2(DATA_WIDTH/8), arburst=01 (INCR), arlock=0, arcache=0, arprot=001.
- Reset (synchronous, active-high): state=IDLE, arvalid=0, araddr=0, arid=0, arlen=0, buffer empty, drop=0. As a result resp_valid=0, req_ready=0, rready=0, busy=0. Reset mid-burst abandons everything; the interconnect shares the same reset.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Grant g = lowest index with req_valid set. req_ready[g]=1 combinationally in that cycle only.
  - On the next edge, latch arid=g, araddr=map(req_addr[g]), arlen=req_len[g]; set arvalid=1; go to ADDR.
  - flush in IDLE has no effect and is not remembered.
- ADDR:
  - arvalid and the AR fields stay stable until arvalid&&arready.
  - On handshake: arvalid<=0, go to DATA.
  - flush here sets drop=1; the AR handshake still completes.
- DATA, normal operation:
  - rready = !buf_valid || resp_ready[g].
  - On rvalid&&rready, the buffer captures rdata, rlast, and (rresp!=0).
  - resp_valid[g]=buf_valid; every other resp_valid bit is 0.
  - A beat is consumed on resp_valid[g]&&resp_ready[g]. When resp_last is consumed, go to IDLE.
  - Simultaneous consume and capture keeps the buffer full, giving one beat per cycle.
- DATA with drop=1:
  - rready=1, the buffer is cleared, resp_valid=0.
  - On rvalid&&rlast, go to IDLE and clear drop.
  - flush in DATA with drop=0 sets drop and clears the buffer in the same edge.
- Protocol checking: a beat with rid != arid is a protocol violation. It is flagged by a simulation assertion only. It is not checked against the beat count; rlast is authoritative.
- Latency with arready and rvalid asserted immediately:
  - Request accepted at cycle 0, arvalid at cycle 1, DATA at cycle 2, beat captured at edge 2, resp_valid at cycle 3.
  - Next request is acceptable in the cycle after the last beat is consumed.
- Starvation: a lower-priority port can be starved by continuous higher-priority requests; this is intended, the same as MEM over IF.
- req_addr and req_len are sampled only at grant; later changes are ignored.

Decomposition:
- Package axi_pkg holds:
  - state encodings READ_IDLE/READ_ADDR/READ_DATA;
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00, PROT_DATA=3'b001;
  - function kseg_map(addr).
- One sub-module: axi_r_skid, the one-entry response buffer (data/last/err, valid/ready, clear input).
- Arbitration and the FSM live in the top.

Test Plan:
- Single beat: port1 requests 0xBFC00000 with len=0; arready=1 at cycle 1; rdata=0x3C1DBFC0 at cycle 2 -> araddr=0x1FC00000, arid=1, arlen=0; resp_valid[1]=1 at cycle 3 with data 0x3C1DBFC0 and last=1.
- Priority: both ports request in the same cycle (port0 at 0x80001000, port1 at 0xBFC00004) -> req_ready=2'b01 first, araddr=0x00001000; port1 is granted in the first IDLE cycle after port0's last beat is consumed.
- Burst with backpressure: port0 len=3, four beats 0xA0..0xA3 sent back-to-back, resp_ready low for 2 cycles after the first beat -> rready low while the buffer is full; all four beats delivered in order, resp_last only on 0xA3.
- Flush: flush asserted in ADDR with arready delayed 3 cycles, burst len=1 -> AR handshake still completes; both beats drained with rready=1; resp_valid stays 0; busy falls after rlast.
- Error plus reset: rresp=2'b10 on a beat -> resp_err=1 alongside resp_valid. Reset asserted mid-burst -> next cycle all outputs return to reset values and state is IDLE.
